// File: rtl/composite_timing_ctrl.sv
// composite_timing_ctrl
// Frame/line sequencer for the composite video output path. Walks a
// horizontal/vertical counter pair over each frame and decodes every
// position into sync, blanking, active video and pixel coordinates.
// Frames start and stop only on frame boundaries, so the monitor never
// sees a truncated field.
module composite_timing_ctrl #(
  parameter int H_SYNC         = 4,
  parameter int H_BACK         = 6,
  parameter int H_ACTIVE       = 40,
  parameter int H_FRONT        = 2,
  parameter int V_SYNC_LINES   = 3,
  parameter int V_BACK_LINES   = 3,
  parameter int V_ACTIVE_LINES = 20,
  parameter int V_FRONT_LINES  = 2,
  parameter int XW             = 8,
  parameter int YW             = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          sync_,
  output logic          blank,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC_LINES + V_BACK_LINES + V_ACTIVE_LINES + V_FRONT_LINES;

  // Counter-width constants; both counters fit because H_TOTAL <= 2^XW
  // and V_TOTAL <= 2^YW.
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_SYNC_END = XW'(H_SYNC);
  localparam logic [XW-1:0] H_VS_END   = XW'(H_TOTAL - H_SYNC);
  localparam logic [XW-1:0] H_ACT0     = XW'(H_SYNC + H_BACK);
  localparam logic [XW-1:0] H_ACT1     = XW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_SYNC_END = YW'(V_SYNC_LINES);
  localparam logic [YW-1:0] V_ACT0     = YW'(V_SYNC_LINES + V_BACK_LINES);
  localparam logic [YW-1:0] V_ACT1     = YW'(V_SYNC_LINES + V_BACK_LINES + V_ACTIVE_LINES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] hcnt_q, hcnt_d;
  logic [YW-1:0] vcnt_q, vcnt_d;

  // Decoded outputs for the upcoming counter position.
  logic          run_d;
  logic          vsync_line, active_line;
  logic          sync_d, active_d, line_start_d, frame_start_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;

  // Next state and next counter position; enable only matters in IDLE
  // and on the final clock of a frame.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    hcnt_d  = '0;
    vcnt_d  = '0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (hcnt_q == H_LAST) begin
          if (vcnt_q == V_LAST) begin
            if (!enable) state_d = IDLE;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
          vcnt_d = vcnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the next position so the registered outputs line up with the
  // counters in the same clock.
  always_comb begin
    run_d         = (state_d == RUN);
    vsync_line    = (vcnt_d < V_SYNC_END);
    active_line   = (vcnt_d >= V_ACT0) && (vcnt_d < V_ACT1);
    active_d      = run_d && active_line && (hcnt_d >= H_ACT0) && (hcnt_d < H_ACT1);
    sync_d        = 1'b1;
    if (run_d) sync_d = vsync_line ? (hcnt_d >= H_VS_END) : (hcnt_d >= H_SYNC_END);
    x_d           = active_d ? (hcnt_d - H_ACT0) : '0;
    y_d           = active_d ? (vcnt_d - V_ACT0) : '0;
    line_start_d  = run_d && (hcnt_d == '0);
    frame_start_d = run_d && (hcnt_d == '0) && (vcnt_d == '0);
  end

  // State, counters and output registers; reset forces IDLE values at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      sync_       <= 1'b1;
      blank       <= 1'b1;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      sync_       <= sync_d;
      blank       <= !active_d;
      active      <= active_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      running     <= run_d;
    end
  end

endmodule
